// File: rtl/mips_register_file.sv
// mips_register_file: 32 x 32-bit MIPS32 GPR file, two async read ports, one sync write port.
// Ports: clock/reset (async active-high clear); read_reg1/read_reg2 -> read_data1/read_data2
//        (combinational, zero latency); write_reg/write_data/reg_write (rising-edge write).
// Register $0 is a constant zero, never stored. No write-to-read bypass: same-cycle reads see the old value.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // Every specifier must select a real entry so the read muxes have no out-of-range case.
  if (NUM_REGS != (2 ** ADDR_WIDTH)) begin : g_bad_params
    $error("mips_register_file: NUM_REGS must equal 2**ADDR_WIDTH");
  end

  // Storage for $1..$N-1 only; $0 has no flop behind it.
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1:1];

  // Read-side view of the whole file, with entry 0 tied to zero.
  logic [DATA_WIDTH-1:0] rf_view [NUM_REGS];

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_write && (write_reg == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  // Reset is asynchronous and dominates any write presented on the same edge.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        regs_q[g] <= '0;
      end else begin
        regs_q[g] <= regs_d[g];
      end
    end
  end

  assign rf_view[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_view
    assign rf_view[g] = regs_q[g];
  end

  // Reads come straight from the flops. write_data is an ALU function of these outputs,
  // so forwarding write_data here would close a combinational loop.
  assign read_data1 = rf_view[read_reg1];
  assign read_data2 = rf_view[read_reg2];

endmodule

// File: tb/tb_mips_register_file.sv
module tb_mips_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int tests = 0;
  int fails = 0;

  // Reference model: plain array of register contents.
  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [8];

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = r;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [4:0]  a;
    logic        do_rst;

    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd5; read_reg2 = 5'd31;
    #12;
    chk("reset_rd1", read_data1, 32'h0);
    chk("reset_rd2", read_data2, 32'h0);
    tick();
    reset = 1'b0;

    // Async reset mid-cycle, then reset held with a write pending.
    do_write(5'd5, 32'hDEADBEEF);
    read_reg1 = 5'd5;
    #1 chk("load_r5", read_data1, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1 chk("async_reset_r5", read_data1, 32'h0);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h1;
    tick();
    chk("reset_hold_edge1", read_data1, 32'h0);
    tick();
    chk("reset_hold_edge2", read_data1, 32'h0);
    reg_write = 1'b0;
    reset = 1'b0;
    tick();
    chk("after_reset_r5", read_data1, 32'h0);

    // Table-driven write-then-read vectors.
    vecs[0] = '{1'b1, 5'd8,  32'h0000F0F0, 5'd8,  5'd0,  32'h0000F0F0, 32'h0};
    vecs[1] = '{1'b1, 5'd9,  32'h0F0F0000, 5'd8,  5'd9,  32'h0000F0F0, 32'h0F0F0000};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd12, 32'hABCD1234, 5'd12, 5'd8,  32'h0,        32'h0000F0F0};
    vecs[4] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 32'h12345678, 32'h12345678};
    vecs[5] = '{1'b1, 5'd1,  32'h80000001, 5'd1,  5'd31, 32'h80000001, 32'h12345678};
    vecs[6] = '{1'b0, 5'd1,  32'h0,        5'd9,  5'd1,  32'h0F0F0000, 32'h80000001};
    vecs[7] = '{1'b1, 5'd8,  32'h00000001, 5'd8,  5'd9,  32'h00000001, 32'h0F0F0000};
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      reg_write = v.we; write_reg = v.wreg; write_data = v.wdata;
      tick();
      reg_write = 1'b0;
      read_reg1 = v.r1; read_reg2 = v.r2;
      #1;
      chk($sformatf("vec%0d_rd1", i), read_data1, v.exp1);
      chk($sformatf("vec%0d_rd2", i), read_data2, v.exp2);
      if (i == 1) chk("or_result", read_data1 | read_data2, 32'h0F0FF0F0);
    end

    // Same-cycle read of the destination returns the old value until the edge.
    do_write(5'd3, 32'h11111111);
    read_reg1 = 5'd3; write_reg = 5'd3; write_data = 32'h22222222; reg_write = 1'b1;
    #2 chk("same_cycle_before", read_data1, 32'h11111111);
    tick();
    chk("same_cycle_after", read_data1, 32'h22222222);
    reg_write = 1'b0;

    // Write enable low over three edges.
    reg_write = 1'b0; write_reg = 5'd12; write_data = 32'hABCD1234; read_reg2 = 5'd12;
    repeat (3) tick();
    chk("we_low_r12", read_data2, 32'h0);

    // Full sweep of patterns, read back in (i, 31-i) pairs.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A50000 | i);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_%0d", i), read_data1, (i == 0) ? 32'h0 : (32'hA5A50000 | i));
      chk($sformatf("sweep_rd2_%0d", 31 - i), read_data2,
          (i == 31) ? 32'h0 : (32'hA5A50000 | (31 - i)));
    end

    // Randomized traffic against the array model, with occasional reset pulses.
    for (int i = 0; i < 32; i++) model[i] = (i == 0) ? 32'h0 : (32'hA5A50000 | i);
    for (int n = 0; n < 400; n++) begin
      do_rst     = ($urandom_range(0, 24) == 0);
      reg_write  = $urandom_range(0, 1) == 1;
      a          = 5'($urandom_range(0, 31));
      write_reg  = a;
      write_data = $urandom;
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      if (do_rst) begin
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end
      #2;
      chk($sformatf("rand%0d_rd1", n), read_data1, model[read_reg1]);
      chk($sformatf("rand%0d_rd2", n), read_data2, model[read_reg2]);
      @(posedge clock);
      if (!do_rst && reg_write && a != 5'd0) model[a] = write_data;
      #1 reset = 1'b0;
    end
    reg_write = 1'b0;
    #1;
    chk("final_rd1", read_data1, model[read_reg1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
